// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory bus arbiter.
package mem_arb_pkg;

    // Arbiter FSM: idle, or one transaction outstanding for fetch or data.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_e;

    // Which port wins the bus in the current idle cycle.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Width needed to count data grants from 0 up to max_streak inclusive.
    function automatic int unsigned streak_width(input int unsigned max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between fetch and data requests with a bounded data streak
// so that a waiting fetch is served after at most MAX_D_STREAK data grants.
module mem_arb_select
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   i_req_i,
    input  logic   d_req_i,
    input  logic   i_gnt_i,
    input  logic   d_gnt_i,
    output owner_e select_o
);

    localparam int unsigned            StreakW   = streak_width(MAX_D_STREAK);
    localparam logic [StreakW-1:0]     StreakMax = StreakW'(MAX_D_STREAK);

    logic [StreakW-1:0] streak_q, streak_d;

    // Data wins unless a fetch is waiting and the streak has reached its cap.
    always_comb begin
        select_o = OWN_I;
        if (d_req_i && (!i_req_i || (streak_q < StreakMax))) begin
            select_o = OWN_D;
        end
    end

    // Streak counts data grants taken while a fetch was waiting.
    always_comb begin
        streak_d = streak_q;
        if (i_gnt_i) begin
            streak_d = '0;
        end else if (d_gnt_i) begin
            if (i_req_i) begin
                if (streak_q < StreakMax) begin
                    streak_d = streak_q + StreakW'(1);
                end
            end else begin
                streak_d = '0;
            end
        end
    end

    // Streak register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory bus between instruction fetch and
// the load/store unit. One transaction outstanding; flushed fetches complete
// on the bus but their response is dropped.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset,
    // Instruction fetch port
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    input  logic                i_flush,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    // Data port
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    // Memory bus
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_ready,
    input  logic [DATA_W-1:0]   m_rdata,
    output logic                busy
);

    localparam int unsigned BeW = DATA_W / 8;

    arb_state_e          state_q, state_d;
    logic                m_req_q, m_req_d;
    logic                m_we_q, m_we_d;
    logic [BeW-1:0]      m_be_q, m_be_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
    logic                i_rvalid_q, i_rvalid_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                drop_q, drop_d;
    owner_e              select;
    logic                idle;

    mem_arb_select #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_select (
        .clk      (clk),
        .reset    (reset),
        .i_req_i  (i_req),
        .d_req_i  (d_req),
        .i_gnt_i  (i_gnt),
        .d_gnt_i  (d_gnt),
        .select_o (select)
    );

    assign idle = (state_q == ARB_IDLE);

    // Grants only in idle and never while reset is held; flush also blocks fetch.
    always_comb begin
        i_gnt = reset && idle && i_req && !i_flush && (select == OWN_I);
        d_gnt = reset && idle && d_req && (select == OWN_D);
    end

    // Next-state: launch on grant, hold the bus, complete on m_ready.
    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_be_d     = m_be_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        i_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rvalid_d = 1'b0;
        d_rdata_d  = d_rdata_q;
        drop_d     = drop_q;

        unique case (state_q)
            ARB_IDLE: begin
                drop_d = 1'b0;
                if (i_gnt) begin
                    state_d   = ARB_BUSY_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_be_d    = '1;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                end else if (d_gnt) begin
                    state_d   = ARB_BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_be_d    = d_be;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                end
            end
            ARB_BUSY_I: begin
                if (i_flush) begin
                    drop_d = 1'b1;
                end
                if (m_ready) begin
                    state_d = ARB_IDLE;
                    m_req_d = 1'b0;
                    drop_d  = 1'b0;
                    // A flush in the completion cycle itself still drops the data.
                    if (!drop_q && !i_flush) begin
                        i_rvalid_d = 1'b1;
                        i_rdata_d  = m_rdata;
                    end
                end
            end
            ARB_BUSY_D: begin
                if (m_ready) begin
                    state_d    = ARB_IDLE;
                    m_req_d    = 1'b0;
                    d_rvalid_d = 1'b1;
                    d_rdata_d  = m_we_q ? '0 : m_rdata;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                m_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any bus transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ARB_IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_be_q     <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            i_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_be_q     <= m_be_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            i_rvalid_q <= i_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rvalid_q <= d_rvalid_d;
            d_rdata_q  <= d_rdata_d;
            drop_q     <= drop_d;
        end
    end

    // Registered outputs.
    always_comb begin
        m_req    = m_req_q;
        m_we     = m_we_q;
        m_be     = m_be_q;
        m_addr   = m_addr_q;
        m_wdata  = m_wdata_q;
        i_rvalid = i_rvalid_q;
        i_rdata  = i_rdata_q;
        d_rvalid = d_rvalid_q;
        d_rdata  = d_rdata_q;
        busy     = (state_q != ARB_IDLE);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported unified memory bus between the core's instruction-fetch port (IF stage, read-only) and data port (LSU, load/store).
- Allows exactly one outstanding transaction.
- Data requests have priority; a bounded-streak rule guarantees fetch forward progress.
- Supports fetch flush on taken branch: the in-flight fetch completes on the bus, but its response is discarded.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8
MAX_D_STREAK, 4, max consecutive data grants issued while i_req is pending (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
i_req  in  1  fetch request; held with i_addr until i_gnt
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  fetch accepted this cycle
i_flush  in  1  discard pending/in-flight fetch response
i_rvalid  out  1  fetch response pulse
i_rdata  out  DATA_W  fetch data
d_req  in  1  data request; held with fields until d_gnt
d_we  in  1  1 = store
d_be  in  BE_W  byte enables
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data accepted this cycle
d_rvalid  out  1  data response/store-ack pulse
d_rdata  out  DATA_W  load data; 0 for stores
m_req  out  1  bus request; held until m_ready
m_we  out  1  bus write
m_be  out  BE_W  bus byte enables
m_addr  out  ADDR_W  bus address
m_wdata  out  DATA_W  bus write data
m_ready  in  1  bus completion; m_rdata valid in the same cycle
m_rdata  in  DATA_W  bus read data
busy  out  1  transaction outstanding (state != IDLE)

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D.
- Reset (reset==0 at a clk edge):
  - state is IDLE; streak counter and drop flag are 0.
  - All m_* outputs, i_rvalid, d_rvalid, i_rdata, d_rdata and busy are 0.
  - i_gnt and d_gnt are forced 0 while reset is low.
- Grant:
  - Grants are combinational and asserted only in IDLE. The transaction is accepted at the edge where req&gnt.
  - i_gnt is also forced 0 when i_flush=1.
  - Winner selection: if d_req and (!i_req or streak<MAX_D_STREAK), data wins; if i_req and (!d_req or streak==MAX_D_STREAK), fetch wins.
- Streak counter:
  - Increments, saturating, on a data grant while i_req=1.
  - Clears on any fetch grant and on a data grant while i_req=0.
- Launch: the edge after the grant registers m_req=1 and the winner's fields (fetch: m_we=0, m_be=all ones, m_wdata=0), and moves to BUSY_I or BUSY_D.
- Bus hold: m_* stay stable while m_req=1 and m_ready=0.
- Completion:
  - At the edge where m_ready=1 in BUSY_x: m_req←0, state←IDLE, and the x_rvalid pulse is registered for one cycle with x_rdata←m_rdata (d_rdata←0 for stores).
  - Minimum latency with a zero-wait bus: grant cycle 0, m_req cycle 1, rvalid cycle 2.
  - A new grant may occur in cycle 2, giving 1 transaction per 2 cycles.
- m_ready in IDLE is ignored.
- Flush:
  - i_flush=1 in any cycle of BUSY_I, including the m_ready cycle, sets the drop flag.
  - On completion with the drop flag set, i_rvalid stays 0; the flag clears on return to IDLE.
  - A flush in the cycle i_rvalid is already high does not retract the pulse.
  - A flush in IDLE only blocks i_gnt that cycle.
- Reset mid-transaction:
  - The bus transaction is abandoned and m_req drops at the next edge.
  - No response is delivered.
- rdata registers hold their value between pulses.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_e {ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D}
  - owner_e {OWN_I, OWN_D}
  - streak counter width function $clog2(MAX_D_STREAK+1)
- One natural sub-module, mem_arb_select: winner logic plus streak counter. Inputs: i_req, d_req, grant strobes. Output: select.

Test Plan:
1. Zero-wait fetch: i_req, i_addr=0x10 in cycle 0, m_ready=1 with m_rdata=0x00500093 in cycle 1.
   → i_gnt=1 in cycle 0; m_req=1, m_addr=0x10, m_we=0, m_be=4'hF in cycle 1; i_rvalid=1, i_rdata=0x00500093 in cycle 2.
2. Contention: i_req and d_req both high at cycle 0 with zero-wait bus.
   → d_gnt in cycle 0, d_rvalid in cycle 2; i_gnt in cycle 2, i_rvalid in cycle 4.
3. Starvation bound: i_req and d_req held high, zero-wait bus, MAX_D_STREAK=4.
   → grant order D,D,D,D,I,D,D,D,D,I.
4. Flush: fetch granted, m_ready delayed to cycle 4, i_flush=1 in cycle 2.
   → no i_rvalid; busy=1 for cycles 1–4; a new i_req is granted in cycle 5.
5. Store: d_we=1, d_be=4'b0011, d_addr=0x100, d_wdata=0xDEADBEEF, m_ready after 2 wait cycles.
   → m_we=1, m_be=4'b0011, m_wdata=0xDEADBEEF stable through the wait cycles; d_rvalid=1, d_rdata=0.
6. Reset mid-operation: reset=0 during BUSY_D with m_ready=0.
   → next cycle m_req=0, busy=0, no d_rvalid, streak=0; after release, the first i_req is granted immediately.
